// File: rtl/usrt_tx.sv
`default_nettype none
// ============================================================================
//  Module      : usrt_tx
//  Description : Synchronous serial transmitter. Sends one start bit, eight
//                data bits LSB first, an optional even/odd parity bit and one
//                stop bit. Every bit lasts a programmable number of clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module usrt_tx (
    input  logic        i_Pclk,
    input  logic        i_Reset,
    input  logic        i_Start,
    input  logic [7:0]  i_Data,
    input  logic [13:0] i_Baud,
    input  logic [1:0]  i_Parity,
    output logic        o_Tx,
    output logic        o_Tx_Busy,
    output logic        o_Done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [2:0] c_LAST_BIT = 3'd7;

    state_t      state_q, state_d;
    logic [13:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic [13:0] baud_q, baud_d;
    logic [1:0]  par_q, par_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Counter reload values; a programmed period of zero behaves as one clock.
    logic [13:0] w_load_in;   // from the live input, used when a frame starts
    logic [13:0] w_load;      // from the latched copy, used for later bits
    logic        w_par_en;
    logic        w_par_bit;
    logic [2:0]  w_idx_nxt;
    logic        w_bit_end;

    assign w_load_in = (i_Baud == 14'd0) ? 14'd0 : (i_Baud - 14'd1);
    assign w_load    = (baud_q == 14'd0) ? 14'd0 : (baud_q - 14'd1);
    assign w_par_en  = (par_q == 2'b01) || (par_q == 2'b10);
    assign w_par_bit = (par_q == 2'b10) ? ~(^data_q) : (^data_q);
    assign w_idx_nxt = idx_q + 3'd1;
    assign w_bit_end = (cnt_q == 14'd0);

    // State and registered outputs; reset aborts any frame without a done pulse.
    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 14'd0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
            baud_q  <= 14'd0;
            par_q   <= 2'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            baud_q  <= baud_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; line value is computed one cycle ahead so o_Tx is a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        baud_d  = baud_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (i_Start) begin
                    data_d  = i_Data;
                    baud_d  = i_Baud;
                    par_d   = i_Parity;
                    cnt_d   = w_load_in;
                    idx_d   = 3'd0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    cnt_d   = w_load;
                    idx_d   = 3'd0;
                    tx_d    = data_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 14'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    cnt_d = w_load;
                    if (idx_q == c_LAST_BIT) begin
                        if (w_par_en) begin
                            tx_d    = w_par_bit;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        idx_d = w_idx_nxt;
                        tx_d  = data_q[w_idx_nxt];
                    end
                end else begin
                    cnt_d = cnt_q - 14'd1;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    cnt_d   = w_load;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - 14'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 14'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_Tx      = tx_q;
    assign o_Tx_Busy = busy_q;
    assign o_Done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_usrt_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usrt_tx
//  Description : Self-checking bench for usrt_tx. A frame-level model expands
//                each accepted request into its per-cycle line waveform and is
//                compared every cycle; directed frames also check literal
//                bit patterns and frame lengths.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usrt_tx;

    logic        i_Pclk = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_Start = 1'b0;
    logic [7:0]  i_Data = 8'd0;
    logic [13:0] i_Baud = 14'd0;
    logic [1:0]  i_Parity = 2'd0;
    logic        o_Tx;
    logic        o_Tx_Busy;
    logic        o_Done;

    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;

    usrt_tx dut (
        .i_Pclk    (i_Pclk),
        .i_Reset   (i_Reset),
        .i_Start   (i_Start),
        .i_Data    (i_Data),
        .i_Baud    (i_Baud),
        .i_Parity  (i_Parity),
        .o_Tx      (o_Tx),
        .o_Tx_Busy (o_Tx_Busy),
        .o_Done    (o_Done)
    );

    always #5 i_Pclk = ~i_Pclk;

    // ---------------- frame-level model ----------------
    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } exp_t;

    localparam exp_t c_IDLE = '{tx: 1'b1, busy: 1'b0, done: 1'b0};

    exp_t q[$];
    exp_t cur = c_IDLE;

    // Expand one request into its cycle-by-cycle waveform.
    task automatic build_frame(input logic [7:0] d, input logic [13:0] baud, input logic [1:0] par);
        int   n;
        logic bits[$];
        n = (baud == 14'd0) ? 1 : int'(baud);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (par == 2'b01) bits.push_back(^d);
        if (par == 2'b10) bits.push_back(~(^d));
        bits.push_back(1'b1);
        foreach (bits[b])
            for (int c = 0; c < n; c++) q.push_back('{tx: bits[b], busy: 1'b1, done: 1'b0});
        q.push_back('{tx: 1'b1, busy: 1'b0, done: 1'b1});
    endtask

    always @(posedge i_Pclk) begin
        if (i_Reset) begin
            q.delete();
            cur = c_IDLE;
        end else begin
            if (!cur.busy && i_Start) build_frame(i_Data, i_Baud, i_Parity);
            if (q.size() > 0) cur = q.pop_front();
            else cur = c_IDLE;
        end
        #2;
        if (chk_en) begin
            vectors++;
            if ({o_Tx, o_Tx_Busy, o_Done} !== cur) begin
                miscompares++;
                $display("FAIL model t=%0t tx/busy/done actual=%b%b%b required=%b%b%b",
                         $time, o_Tx, o_Tx_Busy, o_Done, cur.tx, cur.busy, cur.done);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Request a frame: start high for exactly one rising edge.
    task automatic pulse_start(input logic [7:0] d, input logic [13:0] b, input logic [1:0] p);
        @(negedge i_Pclk);
        i_Data = d; i_Baud = b; i_Parity = p; i_Start = 1'b1;
        @(negedge i_Pclk);
        i_Start = 1'b0;
    endtask

    // Sample a frame from its first start-bit cycle until o_Done; optionally
    // inject an ignored request at a given offset, or chain a new request on done.
    task automatic collect(input int nn, input int inj_at, input logic chain,
                           output int len, output logic [10:0] bits, output int busy_low);
        len = 0; bits = '0; busy_low = 0;
        while (!o_Done && len < 2000) begin
            if ((len % nn) == 0 && (len / nn) < 11) bits[len / nn] = o_Tx;
            if (!o_Tx_Busy) busy_low++;
            if (len == inj_at) begin
                i_Start = 1'b1; i_Data = 8'hFF; i_Baud = 14'd2;
            end else if (len == inj_at + 1) begin
                i_Start = 1'b0;
            end
            len++;
            @(negedge i_Pclk);
        end
        if (len >= 2000) chk("frame_timeout", len, -1);
        if (chain) begin
            i_Start = 1'b1; i_Data = 8'h00;
        end
    endtask

    int          len, bl;
    logic [10:0] bits;

    initial begin
        repeat (3) @(negedge i_Pclk);
        i_Reset = 1'b0;
        chk_en  = 1'b1;
        chk("reset_tx", int'(o_Tx), 1);
        chk("reset_busy", int'(o_Tx_Busy), 0);
        chk("reset_done", int'(o_Done), 0);

        // N=4, no parity, 0x55
        pulse_start(8'h55, 14'd4, 2'b00);
        collect(4, -5, 1'b0, len, bits, bl);
        chk("len_55", len, 40);
        chk("bits_55", int'(bits), int'(11'b01010101010));
        chk("busy_55", bl, 0);
        repeat (3) @(negedge i_Pclk);

        // N=4, even parity, 0x07
        pulse_start(8'h07, 14'd4, 2'b01);
        collect(4, -5, 1'b0, len, bits, bl);
        chk("len_07_even", len, 44);
        chk("bits_07_even", int'(bits), int'(11'b11000001110));
        repeat (2) @(negedge i_Pclk);

        // N=4, odd parity, 0x07
        pulse_start(8'h07, 14'd4, 2'b10);
        collect(4, -5, 1'b0, len, bits, bl);
        chk("len_07_odd", len, 44);
        chk("bits_07_odd", int'(bits), int'(11'b10000001110));
        repeat (2) @(negedge i_Pclk);

        // Parity code 11 behaves as none
        pulse_start(8'h07, 14'd3, 2'b11);
        collect(3, -5, 1'b0, len, bits, bl);
        chk("len_par11", len, 30);

        // N=0 treated as 1, 0xA3
        pulse_start(8'hA3, 14'd0, 2'b00);
        collect(1, -5, 1'b0, len, bits, bl);
        chk("len_A3", len, 10);
        chk("bits_A3", int'(bits), int'(11'b01101000110));
        repeat (2) @(negedge i_Pclk);

        // N=8 frame with an ignored request and config change mid-frame
        pulse_start(8'h3C, 14'd8, 2'b00);
        collect(8, 20, 1'b0, len, bits, bl);
        chk("len_ignore", len, 80);
        chk("bits_ignore", int'(bits), int'(11'b01001111000));
        bl = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge i_Pclk);
            if (o_Tx_Busy || !o_Tx) bl++;
        end
        chk("no_second_frame", bl, 0);

        // Reset during data bit 3
        pulse_start(8'hF0, 14'd4, 2'b01);
        repeat (17) @(negedge i_Pclk);
        i_Reset = 1'b1;
        @(negedge i_Pclk);
        i_Reset = 1'b0;
        chk("abort_tx", int'(o_Tx), 1);
        chk("abort_busy", int'(o_Tx_Busy), 0);
        bl = 0;
        for (int i = 0; i < 60; i++) begin
            if (o_Done) bl++;
            @(negedge i_Pclk);
        end
        chk("abort_no_done", bl, 0);
        pulse_start(8'h55, 14'd4, 2'b00);
        collect(4, -5, 1'b0, len, bits, bl);
        chk("len_after_abort", len, 40);
        chk("bits_after_abort", int'(bits), int'(11'b01010101010));

        // Back-to-back: request held on the done cycle
        repeat (2) @(negedge i_Pclk);
        pulse_start(8'h81, 14'd2, 2'b00);
        collect(2, -5, 1'b1, len, bits, bl);
        chk("len_first", len, 20);
        chk("done_busy_low", int'(o_Tx_Busy), 0);
        @(negedge i_Pclk);
        i_Start = 1'b0;
        chk("chain_tx_low", int'(o_Tx), 0);
        chk("chain_busy", int'(o_Tx_Busy), 1);
        collect(2, -5, 1'b0, len, bits, bl);
        chk("len_chain", len, 20);
        chk("bits_chain", int'(bits), int'(11'b01000000000));
        chk("busy_chain", bl, 0);

        repeat (5) @(negedge i_Pclk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
